// File: rtl/frame_buffer_pp_pkg.sv
// Shared types for the camera frame buffer: clear-engine states and counter width.
package frame_buffer_pp_pkg;

  localparam int FRAME_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } fb_state_t;

endpackage

// File: rtl/frame_buffer_pp_ram_core.sv
// Simple dual-port pixel RAM: one write port, one registered read port, read-first on collision.
module frame_buffer_pp_ram_core #(
  parameter int AW        = 16,
  parameter int DW        = 8,
  parameter     INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Both ports in one process so a same-cell read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_buffer_pp.sv
// Ping-pong frame buffer: writer fills the back bank, reader scans the front bank, swap on frame end,
// plus a clear engine that fills the back bank and defers any swap requested while it runs.
module frame_buffer_pp
  import frame_buffer_pp_pkg::*;
#(
  parameter int AW         = 15,
  parameter int DW         = 8,
  parameter int DEPTH      = 19200,
  parameter int DOUBLE_BUF = 1,
  parameter     INIT_FILE  = ""
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [AW-1:0]          wr_addr,
  input  logic [DW-1:0]          wr_data,
  input  logic                   wr_frame_done,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  output logic [DW-1:0]          rd_data,
  output logic                   rd_valid,
  input  logic                   clr_start,
  input  logic [DW-1:0]          clr_value,
  output logic                   busy,
  output logic                   front_bank,
  output logic                   swap_pending,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int            PAW      = AW + DOUBLE_BUF;
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic          DB       = (DOUBLE_BUF != 0);

  fb_state_t     state, state_nxt;
  logic [AW-1:0] clr_ptr;
  logic [DW-1:0] clr_val;
  logic          swap, pending_nxt, rst_done, rd_zero;
  logic          wr_in_range, rd_in_range, back_bank;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata, ram_q;
  logic [AW:0]   wr_full, rd_full;

  assign busy        = (state == ST_CLEAR);
  assign wr_ready    = rst_done & ~busy;
  assign back_bank   = front_bank ^ DB;
  assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;

  always_comb begin
    state_nxt   = state;
    swap        = 1'b0;
    pending_nxt = swap_pending;
    case (state)
      ST_IDLE: begin
        swap = wr_frame_done;
        if (clr_start) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        pending_nxt = swap_pending | wr_frame_done;
        if (clr_ptr == LAST_PTR) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        swap        = swap_pending | wr_frame_done;
        pending_nxt = 1'b0;
        state_nxt   = clr_start ? ST_CLEAR : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The clear engine owns the write port while busy; wr_ready is low then, so nothing is lost.
  always_comb begin
    ram_we    = wr_valid & wr_ready & wr_in_range;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    if (busy) begin
      ram_we    = 1'b1;
      ram_waddr = clr_ptr;
      ram_wdata = clr_val;
    end
  end

  assign wr_full = {back_bank, ram_waddr};
  assign rd_full = {front_bank, rd_addr};

  frame_buffer_pp_ram_core #(
    .AW        (PAW),
    .DW        (DW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_full[PAW-1:0]),
    .wdata (ram_wdata),
    .re    (rd_en),
    .raddr (rd_full[PAW-1:0]),
    .rdata (ram_q)
  );

  // rd_zero masks both out-of-range reads and the undefined RAM output after reset.
  assign rd_data = rd_zero ? '0 : ram_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      clr_ptr      <= '0;
      clr_val      <= '0;
      swap_pending <= 1'b0;
      front_bank   <= 1'b0;
      frame_cnt    <= '0;
      rst_done     <= 1'b0;
      rd_valid     <= 1'b0;
      rd_zero      <= 1'b1;
    end else begin
      state        <= state_nxt;
      swap_pending <= pending_nxt;
      rst_done     <= 1'b1;
      rd_valid     <= rd_en;
      if (rd_en) rd_zero <= ~rd_in_range;
      if (busy) begin
        clr_ptr <= clr_ptr + 1'b1;
      end else begin
        clr_ptr <= '0;
        if (clr_start) clr_val <= clr_value;
      end
      if (swap) begin
        frame_cnt <= frame_cnt + 1'b1;
        if (DB) front_bank <= ~front_bank;
      end
    end
  end

endmodule

// File: tb/tb_frame_buffer_pp.sv
// Directed bench: a double-buffered and a single-bank instance share stimulus; each test checks one of them.
module tb_frame_buffer_pp;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic wr_frame_done = 1'b0;
  logic rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic clr_start = 1'b0;
  logic [DW-1:0] clr_value = '0;

  logic          d_wr_ready, d_rd_valid, d_busy, d_front, d_pend;
  logic [DW-1:0] d_rd_data;
  logic [7:0]    d_cnt;
  logic          s_wr_ready, s_rd_valid, s_busy, s_front, s_pend;
  logic [DW-1:0] s_rd_data;
  logic [7:0]    s_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  frame_buffer_pp #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .DOUBLE_BUF(1), .INIT_FILE("")) u_db (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(d_wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_frame_done(wr_frame_done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(d_rd_data), .rd_valid(d_rd_valid), .clr_start(clr_start), .clr_value(clr_value),
    .busy(d_busy), .front_bank(d_front), .swap_pending(d_pend), .frame_cnt(d_cnt));

  frame_buffer_pp #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .DOUBLE_BUF(0), .INIT_FILE("")) u_sb (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(s_wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_frame_done(wr_frame_done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .clr_start(clr_start), .clr_value(clr_value),
    .busy(s_busy), .front_bank(s_front), .swap_pending(s_pend), .frame_cnt(s_cnt));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (d_wr_ready !== 1'b0) begin failures++; $display("FAIL rst_wr_ready got=%b exp=0", d_wr_ready); end
    checks++; if (d_rd_data !== 8'h00 || d_rd_valid !== 1'b0) begin failures++; $display("FAIL rst_rd got=%h/%b exp=00/0", d_rd_data, d_rd_valid); end
    checks++; if (d_busy !== 1'b0 || d_front !== 1'b0 || d_pend !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b%b exp=000", d_busy, d_front, d_pend); end
    checks++; if (d_cnt !== 8'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", d_cnt); end
    rst_n = 1'b1;
    step();
    checks++; if (d_wr_ready !== 1'b1) begin failures++; $display("FAIL post_rst_wr_ready got=%b exp=1", d_wr_ready); end
  endtask

  task automatic run_clear(input logic [DW-1:0] val, output int edges);
    clr_start = 1'b1;
    clr_value = val;
    step();
    clr_start = 1'b0;
    edges = 1;
    while (d_busy === 1'b1 && edges < 40) begin
      step();
      edges++;
    end
  endtask

  task automatic test_clear();
    int edges;
    clr_start = 1'b1;
    clr_value = 8'hFF;
    step();
    clr_start = 1'b0;
    checks++; if (d_busy !== 1'b1 || d_wr_ready !== 1'b0) begin failures++; $display("FAIL clr_busy got=%b/%b exp=1/0", d_busy, d_wr_ready); end
    edges = 1;
    while (d_busy === 1'b1 && edges < 40) begin
      step();
      edges++;
    end
    checks++; if (edges !== DEPTH + 1) begin failures++; $display("FAIL clr_len got=%0d exp=%0d", edges, DEPTH + 1); end
    checks++; if (d_wr_ready !== 1'b1 || d_front !== 1'b0) begin failures++; $display("FAIL clr_after got=%b/%b exp=1/0", d_wr_ready, d_front); end
    wr_frame_done = 1'b1;
    step();
    wr_frame_done = 1'b0;
    checks++; if (d_front !== 1'b1 || d_cnt !== 8'd1) begin failures++; $display("FAIL swap1 got=%b/%0d exp=1/1", d_front, d_cnt); end
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1'b1;
      rd_addr = AW'(i);
      step();
      checks++; if (d_rd_data !== 8'hFF || d_rd_valid !== 1'b1) begin failures++; $display("FAIL clr_read[%0d] got=%h/%b exp=ff/1", i, d_rd_data, d_rd_valid); end
    end
    rd_en = 1'b0;
    run_clear(8'h00, edges);
    checks++; if (edges !== DEPTH + 1) begin failures++; $display("FAIL clr2_len got=%0d exp=%0d", edges, DEPTH + 1); end
  endtask

  task automatic test_write_swap();
    wr_valid = 1'b1; wr_addr = 5'd10; wr_data = 8'hA5;
    step();
    wr_valid = 1'b0;
    rd_en = 1'b1; rd_addr = 5'd10;
    step();
    rd_en = 1'b0;
    checks++; if (d_rd_data !== 8'hFF) begin failures++; $display("FAIL noswap_read got=%h exp=ff", d_rd_data); end
    wr_frame_done = 1'b1;
    step();
    wr_frame_done = 1'b0;
    checks++; if (d_front !== 1'b0 || d_cnt !== 8'd2) begin failures++; $display("FAIL swap2 got=%b/%0d exp=0/2", d_front, d_cnt); end
    checks++; if (s_front !== 1'b0 || s_cnt !== 8'd2) begin failures++; $display("FAIL sb_swap got=%b/%0d exp=0/2", s_front, s_cnt); end
    rd_en = 1'b1; rd_addr = 5'd10;
    step();
    rd_en = 1'b0;
    checks++; if (d_rd_data !== 8'hA5 || d_rd_valid !== 1'b1) begin failures++; $display("FAIL swap_read got=%h/%b exp=a5/1", d_rd_data, d_rd_valid); end
    step();
    checks++; if (d_rd_data !== 8'hA5 || d_rd_valid !== 1'b0) begin failures++; $display("FAIL rd_hold got=%h/%b exp=a5/0", d_rd_data, d_rd_valid); end
  endtask

  task automatic test_back_to_back();
    wr_frame_done = 1'b1;
    rd_en = 1'b1; rd_addr = 5'd10;
    wr_valid = 1'b1; wr_addr = 5'd10; wr_data = 8'h3C;
    step();
    wr_frame_done = 1'b0;
    wr_valid = 1'b0;
    checks++; if (d_rd_data !== 8'hA5) begin failures++; $display("FAIL swapcyc_read got=%h exp=a5", d_rd_data); end
    checks++; if (d_front !== 1'b1 || d_cnt !== 8'd3) begin failures++; $display("FAIL swap3 got=%b/%0d exp=1/3", d_front, d_cnt); end
    step();
    rd_en = 1'b0;
    checks++; if (d_rd_data !== 8'h3C) begin failures++; $display("FAIL swapcyc_write got=%h exp=3c", d_rd_data); end
  endtask

  task automatic test_out_of_range();
    wr_valid = 1'b1; wr_addr = 5'd16; wr_data = 8'h77;
    step();
    wr_valid = 1'b0;
    wr_frame_done = 1'b1;
    step();
    wr_frame_done = 1'b0;
    checks++; if (d_front !== 1'b0 || d_cnt !== 8'd4) begin failures++; $display("FAIL swap4 got=%b/%0d exp=0/4", d_front, d_cnt); end
    rd_en = 1'b1; rd_addr = 5'd16;
    step();
    checks++; if (d_rd_data !== 8'h00 || d_rd_valid !== 1'b1) begin failures++; $display("FAIL oor_read got=%h/%b exp=00/1", d_rd_data, d_rd_valid); end
    rd_addr = 5'd10;
    step();
    checks++; if (d_rd_data !== 8'hA5) begin failures++; $display("FAIL oor_keep10 got=%h exp=a5", d_rd_data); end
    rd_addr = 5'd0;
    step();
    rd_en = 1'b0;
    checks++; if (d_rd_data !== 8'h00) begin failures++; $display("FAIL oor_keep0 got=%h exp=00", d_rd_data); end
  endtask

  task automatic test_single_bank();
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 8'h11;
    rd_en = 1'b1; rd_addr = 5'd5;
    step();
    wr_valid = 1'b0;
    checks++; if (s_rd_data !== 8'h00 || s_rd_valid !== 1'b1) begin failures++; $display("FAIL sb_rdfirst got=%h/%b exp=00/1", s_rd_data, s_rd_valid); end
    step();
    rd_en = 1'b0;
    checks++; if (s_rd_data !== 8'h11) begin failures++; $display("FAIL sb_reread got=%h exp=11", s_rd_data); end
  endtask

  task automatic test_pending_swap();
    int guard;
    clr_start = 1'b1; clr_value = 8'h5A;
    step();
    clr_start = 1'b0;
    step();
    wr_frame_done = 1'b1;
    step();
    checks++; if (d_pend !== 1'b1 || d_front !== 1'b0) begin failures++; $display("FAIL pend_set got=%b/%b exp=1/0", d_pend, d_front); end
    step();
    wr_frame_done = 1'b0;
    guard = 0;
    while (d_busy === 1'b1 && guard < 40) begin
      step();
      guard++;
    end
    checks++; if (d_busy !== 1'b0 || d_pend !== 1'b1 || d_front !== 1'b0) begin failures++; $display("FAIL pend_done got=%b%b%b exp=010", d_busy, d_pend, d_front); end
    step();
    checks++; if (d_front !== 1'b1 || d_pend !== 1'b0 || d_cnt !== 8'd5) begin failures++; $display("FAIL pend_apply got=%b/%b/%0d exp=1/0/5", d_front, d_pend, d_cnt); end
    rd_en = 1'b1; rd_addr = 5'd3;
    step();
    rd_en = 1'b0;
    checks++; if (d_rd_data !== 8'h5A) begin failures++; $display("FAIL pend_read got=%h exp=5a", d_rd_data); end
  endtask

  task automatic test_async_reset();
    clr_start = 1'b1; clr_value = 8'h33;
    step();
    clr_start = 1'b0;
    step();
    step();
    checks++; if (d_busy !== 1'b1) begin failures++; $display("FAIL arst_pre got=%b exp=1", d_busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (d_busy !== 1'b0 || d_front !== 1'b0 || d_cnt !== 8'd0 || d_wr_ready !== 1'b0) begin
      failures++; $display("FAIL arst got=%b/%b/%0d/%b exp=0/0/0/0", d_busy, d_front, d_cnt, d_wr_ready);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_clear();
    test_write_swap();
    test_back_to_back();
    test_out_of_range();
    test_single_bank();
    test_pending_swap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
